// File: rtl/spi_frame_pkg.sv
// ---- spi_frame_pkg: shared types and defaults for spi_frame_responder ----
// ---- rev 1.0 ----
`default_nettype none

package spi_frame_pkg;
  localparam int DEFAULT_WORD_W = 16;
  localparam int DEFAULT_CNT_W  = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;
endpackage

`default_nettype wire

// File: rtl/spi_frame_responder_sync_edge.sv
// ---- sync_edge: 2-FF synchroniser plus edge register with rise/fall/level ----
// ---- rev 1.0 ----
`default_nettype none

module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  // stages [0],[1] synchronise; [2] holds the previous synchronised level
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= {3{RESET_VAL}};
    else       sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];
endmodule

`default_nettype wire

// File: rtl/spi_frame_responder.sv
// ---- spi_frame_responder: oversampled mode-0 SPI slave with rx/tx valid-ready streams ----
// ---- rev 1.0 ----
`default_nettype none

module spi_frame_responder
  import spi_frame_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_active,
  output logic [CNT_W-1:0]  word_count,
  input  logic              clear_status,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort
);
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic ss_lvl, ss_rise, ss_fall;

  sync_edge #(.RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge #(.RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
  sync_edge #(.RESET_VAL(1'b1)) u_ss (
    .clk(clk), .reset(reset), .din(ss_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

  spi_state_t        state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] rxsr;
  logic [WORD_W-1:0] txsr;
  logic              pend;

  logic [WORD_W-1:0] rx_word;
  logic [WORD_W-1:0] load_word;
  logic              fetch_tx;
  logic              fetch_empty;

  // A pending word already sits in txsr, so "loading" it means keeping txsr.
  assign rx_word     = {rxsr[WORD_W-2:0], mosi_lvl};
  assign fetch_tx    = ~pend & tx_valid;
  assign fetch_empty = ~pend & ~tx_valid;
  assign load_word   = pend ? txsr : (tx_valid ? tx_data : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rxsr        <= '0;
      txsr        <= '0;
      pend        <= 1'b0;
      tx_ready    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      word_count  <= '0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      // Clears come first so a flag set later in this cycle overrides them.
      if (clear_status) begin
        rx_overrun  <= 1'b0;
        tx_underrun <= 1'b0;
        frame_abort <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state      <= ACTIVE;
            bit_cnt    <= '0;
            word_count <= '0;
            txsr       <= load_word;
            if (fetch_tx)    tx_ready    <= 1'b1;
            if (fetch_empty) tx_underrun <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt != '0) begin
              bit_cnt     <= '0;
              pend        <= 1'b0;
              frame_abort <= 1'b1;
            end
          end else if (sclk_rise) begin
            rxsr <= rx_word;
            pend <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (word_count != '1) word_count <= word_count + 1'b1;
              if (!rx_valid) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt != '0) begin
              txsr <= {txsr[WORD_W-2:0], 1'b0};
            end else begin
              txsr <= load_word;
              pend <= 1'b1;
              if (fetch_tx)    tx_ready    <= 1'b1;
              if (fetch_empty) tx_underrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso         = txsr[WORD_W-1];
  assign miso_oe      = ~ss_lvl;
  assign frame_active = (state == ACTIVE);
endmodule

`default_nettype wire

// File: tb/tb_spi_frame_responder.sv
// ---- tb_spi_frame_responder: directed self-checking bench for spi_frame_responder ----
// ---- rev 1.0 ----
`default_nettype none

module tb_spi_frame_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic        miso, miso_oe;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        frame_active;
  logic [7:0]  word_count;
  logic        clear_status = 1'b0;
  logic        rx_overrun, tx_underrun, frame_abort;

  int tests = 0;
  int fails = 0;
  int tx_count = 0;
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic [15:0] mst_tx[4];
  logic [15:0] mst_rx[4];

  spi_frame_responder #(.WORD_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_active(frame_active), .word_count(word_count),
    .clear_status(clear_status),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_abort(frame_abort));

  always #5 clk = ~clk;

  // Reply-word producer and received-word collector, both working off the falling clock edge.
  always @(negedge clk) begin
    if (tx_ready) begin
      tx_count = tx_count + 1;
      if (txq.size() > 0) void'(txq.pop_front());
    end
    tx_valid = (txq.size() > 0);
    tx_data  = (txq.size() > 0) ? txq[0] : 16'h0000;
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; clear_status = 1'b0;
    txq.delete(); rxq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tx_count = 0;
    repeat (2) @(negedge clk);
  endtask

  // Mode-0 master at f_clk/8: MOSI set on the falling half, MISO sampled just before SCLK rises.
  task automatic spi_xfer(input int nbits, input bit end_frame);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      mosi = mst_tx[b / 16][15 - (b % 16)];
      repeat (4) @(negedge clk);
      mst_rx[b / 16][15 - (b % 16)] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    if (end_frame) begin
      repeat (6) @(negedge clk);
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    tests++; if (rx_data !== 16'h0000) begin fails++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
    tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL reset_frame_active: got %b want 0", frame_active); end
    tests++; if (word_count !== 8'd0) begin fails++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    tests++; if ({rx_overrun, tx_underrun, frame_abort} !== 3'b000) begin fails++;
      $display("FAIL reset_flags: got %b want 000", {rx_overrun, tx_underrun, frame_abort}); end
  endtask

  task automatic test_single_word();
    do_reset();
    rx_ready = 1'b0;
    txq.push_back(16'hA55A);
    mst_tx[0] = 16'h1234;
    repeat (4) @(negedge clk);
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    tests++; if (miso_oe !== 1'b1 || frame_active !== 1'b1) begin fails++;
      $display("FAIL single_start: got oe=%b active=%b want 1 1", miso_oe, frame_active); end
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    do_reset();
    txq.push_back(16'hA55A);
    repeat (4) @(negedge clk);
    spi_xfer(16, 1'b1);
    tests++; if (rx_data !== 16'h1234) begin fails++; $display("FAIL single_rx_data: got %h want 1234", rx_data); end
    tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL single_rx_valid: got %b want 1", rx_valid); end
    tests++; if (mst_rx[0] !== 16'hA55A) begin fails++; $display("FAIL single_master_rx: got %h want a55a", mst_rx[0]); end
    tests++; if (word_count !== 8'd1) begin fails++; $display("FAIL single_word_count: got %0d want 1", word_count); end
    tests++; if (tx_count !== 1) begin fails++; $display("FAIL single_tx_ready: got %0d pulses want 1", tx_count); end
    tests++; if (frame_active !== 1'b0 || miso_oe !== 1'b0) begin fails++;
      $display("FAIL single_end: got active=%b oe=%b want 0 0", frame_active, miso_oe); end
  endtask

  task automatic test_burst();
    do_reset();
    rx_ready = 1'b1;
    txq.push_back(16'h0001); txq.push_back(16'h0002);
    txq.push_back(16'h0003); txq.push_back(16'hBEEF);
    mst_tx[0] = 16'h1111; mst_tx[1] = 16'h2222; mst_tx[2] = 16'h3333;
    repeat (4) @(negedge clk);
    spi_xfer(48, 1'b1);
    tests++; if (mst_rx[0] !== 16'h0001 || mst_rx[1] !== 16'h0002 || mst_rx[2] !== 16'h0003) begin fails++;
      $display("FAIL burst_master_rx: got %h %h %h want 0001 0002 0003", mst_rx[0], mst_rx[1], mst_rx[2]); end
    tests++; if (rxq.size() !== 3) begin fails++; $display("FAIL burst_rx_count: got %0d want 3", rxq.size()); end
    tests++; if (rxq[0] !== 16'h1111 || rxq[1] !== 16'h2222 || rxq[2] !== 16'h3333) begin fails++;
      $display("FAIL burst_rx_order: got %h %h %h want 1111 2222 3333", rxq[0], rxq[1], rxq[2]); end
    tests++; if (word_count !== 8'd3) begin fails++; $display("FAIL burst_word_count: got %0d want 3", word_count); end
    tests++; if (tx_count !== 4) begin fails++; $display("FAIL burst_tx_ready: got %0d pulses want 4", tx_count); end
    mst_tx[0] = 16'h4444;
    spi_xfer(16, 1'b1);
    tests++; if (mst_rx[0] !== 16'hBEEF) begin fails++; $display("FAIL burst_replay: got %h want beef", mst_rx[0]); end
    tests++; if (tx_count !== 4) begin fails++; $display("FAIL burst_no_extra_ready: got %0d pulses want 4", tx_count); end
    tests++; if (word_count !== 8'd1) begin fails++; $display("FAIL burst_second_count: got %0d want 1", word_count); end
  endtask

  task automatic test_underrun();
    do_reset();
    rx_ready = 1'b1;
    mst_tx[0] = 16'h5A5A;
    spi_xfer(16, 1'b1);
    tests++; if (mst_rx[0] !== 16'h0000) begin fails++; $display("FAIL underrun_master_rx: got %h want 0000", mst_rx[0]); end
    tests++; if (rxq.size() !== 1 || rxq[0] !== 16'h5A5A) begin fails++;
      $display("FAIL underrun_rx: got n=%0d %h want n=1 5a5a", rxq.size(), rxq[0]); end
    repeat (10) @(negedge clk);
    tests++; if (tx_underrun !== 1'b1) begin fails++; $display("FAIL underrun_sticky: got %b want 1", tx_underrun); end
    pulse_clear();
    tests++; if (tx_underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear: got %b want 0", tx_underrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    rx_ready = 1'b0;
    txq.push_back(16'h1357); txq.push_back(16'h2468);
    mst_tx[0] = 16'hCAFE; mst_tx[1] = 16'hF00D;
    repeat (4) @(negedge clk);
    spi_xfer(32, 1'b1);
    tests++; if (rx_data !== 16'hCAFE) begin fails++; $display("FAIL overrun_rx_data: got %h want cafe", rx_data); end
    tests++; if (rx_overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b want 1", rx_overrun); end
    tests++; if (word_count !== 8'd2) begin fails++; $display("FAIL overrun_word_count: got %0d want 2", word_count); end
    tests++; if (mst_rx[0] !== 16'h1357 || mst_rx[1] !== 16'h2468) begin fails++;
      $display("FAIL overrun_master_rx: got %h %h want 1357 2468", mst_rx[0], mst_rx[1]); end
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL overrun_drain: got %b want 0", rx_valid); end
  endtask

  task automatic test_abort();
    do_reset();
    rx_ready = 1'b1;
    txq.push_back(16'h7E7E);
    mst_tx[0] = 16'hFFFF;
    repeat (4) @(negedge clk);
    spi_xfer(7, 1'b1);
    tests++; if (rxq.size() !== 0 || rx_valid !== 1'b0) begin fails++;
      $display("FAIL abort_no_rx: got n=%0d valid=%b want 0 0", rxq.size(), rx_valid); end
    tests++; if (frame_abort !== 1'b1) begin fails++; $display("FAIL abort_flag: got %b want 1", frame_abort); end
    tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b want 0", frame_active); end
    tests++; if (word_count !== 8'd0) begin fails++; $display("FAIL abort_word_count: got %0d want 0", word_count); end
    pulse_clear();
    txq.push_back(16'h9669);
    mst_tx[0] = 16'h3C3C;
    repeat (4) @(negedge clk);
    spi_xfer(16, 1'b1);
    tests++; if (rxq.size() !== 1 || rxq[0] !== 16'h3C3C) begin fails++;
      $display("FAIL abort_next_rx: got n=%0d %h want n=1 3c3c", rxq.size(), rxq[0]); end
    tests++; if (mst_rx[0] !== 16'h9669) begin fails++; $display("FAIL abort_next_master_rx: got %h want 9669", mst_rx[0]); end
    tests++; if (frame_abort !== 1'b0) begin fails++; $display("FAIL abort_next_flag: got %b want 0", frame_abort); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    rx_ready = 1'b0;
    txq.push_back(16'h1357);
    mst_tx[0] = 16'hAAAA;
    repeat (4) @(negedge clk);
    spi_xfer(16, 1'b1);
    txq.push_back(16'h8421);
    repeat (4) @(negedge clk);
    spi_xfer(9, 1'b0);
    tests++; if (rx_valid !== 1'b1 || frame_active !== 1'b1) begin fails++;
      $display("FAIL midreset_pre: got valid=%b active=%b want 1 1", rx_valid, frame_active); end
    reset = 1'b1; ss_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (rx_valid !== 1'b0 || rx_data !== 16'h0000) begin fails++;
      $display("FAIL midreset_rx: got valid=%b data=%h want 0 0000", rx_valid, rx_data); end
    tests++; if (frame_active !== 1'b0 || word_count !== 8'd0) begin fails++;
      $display("FAIL midreset_frame: got active=%b count=%0d want 0 0", frame_active, word_count); end
    tests++; if (miso !== 1'b0 || miso_oe !== 1'b0 || tx_ready !== 1'b0) begin fails++;
      $display("FAIL midreset_pins: got miso=%b oe=%b ready=%b want 0 0 0", miso, miso_oe, tx_ready); end
    tests++; if ({rx_overrun, tx_underrun, frame_abort} !== 3'b000) begin fails++;
      $display("FAIL midreset_flags: got %b want 000", {rx_overrun, tx_underrun, frame_abort}); end
    repeat (6) @(negedge clk);
    txq.delete(); rxq.delete();
    rx_ready = 1'b1;
    txq.push_back(16'h2468);
    mst_tx[0] = 16'h0F0F;
    repeat (4) @(negedge clk);
    spi_xfer(16, 1'b1);
    tests++; if (rxq.size() !== 1 || rxq[0] !== 16'h0F0F) begin fails++;
      $display("FAIL midreset_next_rx: got n=%0d %h want n=1 0f0f", rxq.size(), rxq[0]); end
    tests++; if (mst_rx[0] !== 16'h2468) begin fails++; $display("FAIL midreset_next_master_rx: got %h want 2468", mst_rx[0]); end
    tests++; if (word_count !== 8'd1) begin fails++; $display("FAIL midreset_next_count: got %0d want 1", word_count); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_underrun();
    test_overrun();
    test_abort();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
